prefix_add_sequencer: RTL and testbench

- Multi-precision add/subtract controller built around one 16-bit prefix_adder instance.
- Accepts WORDS*16-bit operands over a valid/ready handshake.
- Feeds one 16-bit slice per cycle into the adder, LSB slice first, chaining the carry through a register.
- Presents the assembled result, carry/borrow-out and signed overflow over a second valid/ready handshake.

---
 rtl/prefix_add_sequencer.sv | 170 +++++++++++++++++
 tb/tb_prefix_add_sequencer.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/prefix_add_sequencer.sv
// ============================================================================
// prefix_add_sequencer : multi-precision add/sub, one 16-bit prefix adder,
//                        one slice per cycle, LSB slice first
// Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module prefix_adder (
  input  logic [15:0] i_a,
  input  logic [15:0] i_b,
  input  logic        i_cin,
  output logic [15:0] o_sum,
  output logic        o_cout
);

  logic [4:0][15:0] w_g;
  logic [4:0][15:0] w_p;
  logic [16:0]      w_c;

  assign w_g[0] = i_a & i_b;
  assign w_p[0] = i_a ^ i_b;

  // Kogge-Stone: after level l each bit holds the group (G,P) over 2^(l+1) bits
  genvar l, i;
  generate
    for (l = 0; l < 4; l++) begin : g_level
      for (i = 0; i < 16; i++) begin : g_bit
        if (i >= (1 << l)) begin : g_merge
          assign w_g[l+1][i] = w_g[l][i] | (w_p[l][i] & w_g[l][i-(1<<l)]);
          assign w_p[l+1][i] = w_p[l][i] & w_p[l][i-(1<<l)];
        end else begin : g_pass
          assign w_g[l+1][i] = w_g[l][i];
          assign w_p[l+1][i] = w_p[l][i];
        end
      end
    end

    assign w_c[0] = i_cin;
    for (i = 0; i < 16; i++) begin : g_carry
      assign w_c[i+1] = w_g[4][i] | (w_p[4][i] & i_cin);
    end
  endgenerate

  assign o_sum  = w_p[0] ^ w_c[15:0];
  assign o_cout = w_c[16];

endmodule

module prefix_add_sequencer #(
  parameter int WORDS = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [16*WORDS-1:0] in_a,
  input  logic [16*WORDS-1:0] in_b,
  input  logic                in_op,
  input  logic                in_cin,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [16*WORDS-1:0] out_sum,
  output logic                out_cout,
  output logic                out_ovf
);

  localparam int W  = 16 * WORDS;
  localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IW-1:0] c_LAST_IDX = IW'(WORDS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_next;
  logic [W-1:0]    r_a;
  logic [W-1:0]    r_b;
  logic            r_op;
  logic            r_carry;
  logic [IW-1:0]   r_idx;
  logic [W-1:0]    r_res;
  logic [IW+3:0]   w_base;
  logic [15:0]     w_a_sl;
  logic [15:0]     w_b_sl;
  logic [15:0]     w_sum;
  logic            w_cout;
  logic            w_last;
  logic [W-1:0]    w_final;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next    = r_state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_next = S_RUN;
      end
      S_RUN: begin
        if (r_idx == c_LAST_IDX) w_next = S_DONE;
      end
      S_DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  assign w_base = {r_idx, 4'b0000};
  assign w_a_sl = r_a[w_base +: 16];
  // Subtraction is A + ~B + ~borrow; the inverted borrow is loaded at accept
  assign w_b_sl = r_b[w_base +: 16] ^ {16{r_op}};
  assign w_last = (r_state == S_RUN) && (r_idx == c_LAST_IDX);

  prefix_adder u_adder (
    .i_a    (w_a_sl),
    .i_b    (w_b_sl),
    .i_cin  (r_carry),
    .o_sum  (w_sum),
    .o_cout (w_cout)
  );

  always_comb begin
    w_final = r_res;
    w_final[w_base +: 16] = w_sum;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a      <= '0;
      r_b      <= '0;
      r_op     <= 1'b0;
      r_carry  <= 1'b0;
      r_idx    <= '0;
      r_res    <= '0;
      out_sum  <= '0;
      out_cout <= 1'b0;
      out_ovf  <= 1'b0;
    end else if (in_valid && in_ready) begin
      r_a     <= in_a;
      r_b     <= in_b;
      r_op    <= in_op;
      r_carry <= in_cin ^ in_op;
      r_idx   <= '0;
    end else if (r_state == S_RUN) begin
      r_res[w_base +: 16] <= w_sum;
      r_carry             <= w_cout;
      if (w_last) begin
        out_sum  <= w_final;
        out_cout <= w_cout ^ r_op;
        out_ovf  <= (w_a_sl[15] == w_b_sl[15]) && (w_sum[15] != w_a_sl[15]);
      end else begin
        r_idx <= r_idx + 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_prefix_add_sequencer.sv
// ============================================================================
// tb_prefix_add_sequencer : vector table + scoreboard bench, WORDS=4 and WORDS=1
// Revision: 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_prefix_add_sequencer;

  localparam int WORDS = 4;
  localparam int W     = 64;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid, in_ready, in_op, in_cin;
  logic [W-1:0] in_a, in_b, out_sum;
  logic         out_valid, out_ready, out_cout, out_ovf;

  logic         v1_in_valid, v1_in_ready, v1_in_op, v1_in_cin;
  logic [15:0]  v1_in_a, v1_in_b, v1_out_sum;
  logic         v1_out_valid, v1_out_ready, v1_out_cout, v1_out_ovf;

  prefix_add_sequencer #(.WORDS(WORDS)) u_dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_cin(in_cin),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_cout(out_cout), .out_ovf(out_ovf)
  );

  prefix_add_sequencer #(.WORDS(1)) u_dut_w1 (
    .clk(clk), .rst(rst),
    .in_valid(v1_in_valid), .in_ready(v1_in_ready),
    .in_a(v1_in_a), .in_b(v1_in_b), .in_op(v1_in_op), .in_cin(v1_in_cin),
    .out_valid(v1_out_valid), .out_ready(v1_out_ready),
    .out_sum(v1_out_sum), .out_cout(v1_out_cout), .out_ovf(v1_out_ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] a;
    logic [63:0] b;
    logic        op;
    logic        cin;
    logic [63:0] sum;
    logic        cout;
    logic        ovf;
  } vec_t;

  typedef struct {
    logic [63:0] sum;
    logic        cout;
    logic        ovf;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: plain wide arithmetic, independent of slicing
  function automatic vec_t mk(input logic [63:0] a, input logic [63:0] b,
                              input logic op, input logic cin);
    vec_t        v;
    logic [64:0] r;
    logic [63:0] bp;
    v.a = a; v.b = b; v.op = op; v.cin = cin;
    if (!op) r = {1'b0, a} + {1'b0, b} + 65'(cin);
    else     r = {1'b0, a} - {1'b0, b} - 65'(cin);
    bp     = op ? ~b : b;
    v.sum  = r[63:0];
    v.cout = r[64];
    v.ovf  = (a[63] == bp[63]) && (r[63] != a[63]);
    return v;
  endfunction

  function automatic vec_t mkh(input logic [63:0] a, input logic [63:0] b,
                               input logic op, input logic cin,
                               input logic [63:0] sum, input logic cout, input logic ovf);
    vec_t v;
    v.a = a; v.b = b; v.op = op; v.cin = cin;
    v.sum = sum; v.cout = cout; v.ovf = ovf;
    return v;
  endfunction

  task automatic push_exp(input vec_t v);
    exp_t e;
    e.sum = v.sum; e.cout = v.cout; e.ovf = v.ovf;
    sb.push_back(e);
  endtask

  always @(negedge clk) begin : mon
    exp_t e;
    if (out_valid === 1'b1 && out_ready === 1'b1) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL sb_unexpected: got out_valid=1 expected no pending result");
      end else begin
        e = sb.pop_front();
        chk("sb_sum",  out_sum,          e.sum);
        chk("sb_cout", 64'(out_cout),    64'(e.cout));
        chk("sb_ovf",  64'(out_ovf),     64'(e.ovf));
      end
    end
  end

  task automatic drive(input vec_t v);
    in_a = v.a; in_b = v.b; in_op = v.op; in_cin = v.cin; in_valid = 1'b1;
  endtask

  // Returns 1 once the request has been accepted (called just after an edge)
  task automatic wait_accept(input string tag, output bit ok);
    int t = 0;
    while (in_ready !== 1'b1 && t < 50) begin
      @(posedge clk); #1; t++;
    end
    ok = (t < 50);
    if (!ok) chk({tag, "_accept_timeout"}, 64'(t), 64'd0);
  endtask

  task automatic wait_result(input string tag);
    int t = 0;
    bit rdy_low = 1'b1;
    while (out_valid !== 1'b1 && t < 20) begin
      if (in_ready !== 1'b0) rdy_low = 1'b0;
      @(posedge clk); #1; t++;
    end
    chk({tag, "_latency"}, 64'(t), 64'(WORDS));
    chk({tag, "_in_ready_low"}, 64'(rdy_low), 64'd1);
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    bit ok;
    drive(v);
    wait_accept(tag, ok);
    if (!ok) begin
      in_valid = 1'b0;
      return;
    end
    push_exp(v);
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_result(tag);
    @(posedge clk); #1;
    chk({tag, "_idle_after"}, 64'({in_ready, out_valid}), 64'(2'b10));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected end of test");
    $fatal(1);
  end

  initial begin
    vec_t vecs[10];
    vec_t va, vb, vc;
    bit   ok;
    bit   stale;
    int   t;

    vecs[0] = mkh(64'h0000_0000_0000_FFFF, 64'd1, 1'b0, 1'b0, 64'h0000_0000_0001_0000, 1'b0, 1'b0);
    vecs[1] = mkh(64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b0, 1'b1, 64'h0, 1'b1, 1'b0);
    vecs[2] = mkh(64'd0, 64'd1, 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0);
    vecs[3] = mkh(64'd5, 64'd3, 1'b1, 1'b1, 64'd1, 1'b0, 1'b0);
    vecs[4] = mkh(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1);
    vecs[5] = mkh(64'h8000_0000_0000_0000, 64'd1, 1'b1, 1'b0, 64'h7FFF_FFFF_FFFF_FFFF, 1'b0, 1'b1);
    for (int i = 6; i < 10; i++)
      vecs[i] = mk({$urandom(), $urandom()}, {$urandom(), $urandom()},
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));

    rst = 1'b1;
    in_valid = 1'b0; in_a = '0; in_b = '0; in_op = 1'b0; in_cin = 1'b0;
    out_ready = 1'b1;
    v1_in_valid = 1'b0; v1_in_a = '0; v1_in_b = '0; v1_in_op = 1'b0; v1_in_cin = 1'b0;
    v1_out_ready = 1'b1;

    #12;
    chk("rst_handshake", 64'({in_ready, out_valid}), 64'(2'b10));
    chk("rst_sum",       out_sum, 64'h0);
    chk("rst_flags",     64'({out_cout, out_ovf}), 64'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    for (int i = 0; i < 10; i++)
      run_vec(vecs[i], $sformatf("vec%0d", i));

    // Backpressure: result held in DONE while a new request waits
    va = mk(64'h1234_5678_9ABC_DEF0, 64'h0FED_CBA9_8765_4321, 1'b0, 1'b1);
    vb = mk(64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222, 1'b1, 1'b0);
    out_ready = 1'b0;
    drive(va);
    wait_accept("bp_a", ok);
    push_exp(va);
    @(posedge clk); #1;
    in_valid = 1'b0;
    wait_result("bp_a");
    drive(vb);
    for (int c = 0; c < 6; c++) begin
      chk($sformatf("bp_hold_sum%0d", c), out_sum, va.sum);
      chk($sformatf("bp_hold_hs%0d", c), 64'({in_ready, out_valid}), 64'(2'b01));
      @(posedge clk); #1;
    end
    chk("bp_hold_flags", 64'({out_cout, out_ovf}), 64'({va.cout, va.ovf}));
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_idle", 64'({in_ready, out_valid}), 64'(2'b10));
    push_exp(vb);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("bp_b_accepted", 64'(in_ready), 64'd0);
    wait_result("bp_b");
    @(posedge clk); #1;

    // Reset while slice 2 is in flight
    vc = mk(64'hAAAA_BBBB_CCCC_DDDD, 64'h0123_4567_89AB_CDEF, 1'b0, 1'b0);
    drive(vc);
    wait_accept("rst_run", ok);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #2;
    rst = 1'b1;
    #1;
    chk("rst_async_hs",  64'({in_ready, out_valid}), 64'(2'b10));
    chk("rst_async_sum", out_sum, 64'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_release_ready", 64'(in_ready), 64'd1);
    stale = 1'b0;
    for (int c = 0; c < 10; c++) begin
      if (out_valid !== 1'b0) stale = 1'b1;
      @(posedge clk); #1;
    end
    chk("rst_no_stale_valid", 64'(stale), 64'd0);

    // WORDS=1 instance
    v1_in_a = 16'hFFFF; v1_in_b = 16'h0001; v1_in_op = 1'b0; v1_in_cin = 1'b0;
    v1_in_valid = 1'b1;
    t = 0;
    while (v1_in_ready !== 1'b1 && t < 50) begin
      @(posedge clk); #1; t++;
    end
    chk("w1_accept", 64'(t < 50), 64'd1);
    @(posedge clk); #1;
    v1_in_valid = 1'b0;
    t = 0;
    while (v1_out_valid !== 1'b1 && t < 20) begin
      @(posedge clk); #1; t++;
    end
    chk("w1_latency", 64'(t), 64'd1);
    chk("w1_sum",     64'(v1_out_sum), 64'h0);
    chk("w1_flags",   64'({v1_out_cout, v1_out_ovf}), 64'(2'b10));
    @(posedge clk); #1;
    chk("w1_idle", 64'({v1_in_ready, v1_out_valid}), 64'(2'b10));

    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
